// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// then shifts one byte out on device-generated clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kb_clk_in,
    input  logic       kb_data_in,
    output logic       kb_clk_drive_low,
    output logic       kb_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StBits,
        StAck,
        StWaitRel
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_prev_q;
    logic [7:0]      byte_q, byte_d;
    logic            parity_q, parity_d;
    logic [3:0]      nfall_q, nfall_d, nfall_inc;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            nack_q, nack_d;
    logic            clk_low_q, clk_low_d;
    logic            data_low_q, data_low_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            sync_clk, sync_data, fall, handshake;

    // Synchronisers idle high so reset never fakes a fall on the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], kb_clk_in};
            data_sync_q <= {data_sync_q[0], kb_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign sync_clk  = clk_sync_q[1];
    assign sync_data = data_sync_q[1];
    assign fall      = clk_prev_q & ~sync_clk;
    assign handshake = tx_valid & ready_q;
    assign nfall_inc = (nfall_q == 4'd11) ? 4'd11 : nfall_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            byte_q     <= 8'h00;
            parity_q   <= 1'b0;
            nfall_q    <= 4'd0;
            cnt_q      <= '0;
            nack_q     <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            parity_q   <= parity_d;
            nfall_q    <= nfall_d;
            cnt_q      <= cnt_d;
            nack_q     <= nack_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        parity_d   = parity_q;
        nfall_d    = nfall_q;
        cnt_d      = cnt_q;
        nack_d     = nack_q;
        clk_low_d  = 1'b0;
        data_low_d = data_low_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                data_low_d = 1'b0;
                if (handshake) begin
                    state_d    = StInhibit;
                    byte_d     = tx_data;
                    parity_d   = ~^tx_data;
                    nfall_d    = 4'd0;
                    cnt_d      = '0;
                    nack_d     = 1'b0;
                    clk_low_d  = 1'b1;
                    data_low_d = (INHIBIT_CYCLES < 2);
                end
            end
            StInhibit: begin
                if (cnt_q == InhibitLast) begin
                    state_d    = StBits;
                    cnt_d      = '0;
                    data_low_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CntW'(1);
                    clk_low_d  = 1'b1;
                    // Start bit goes out during the final inhibit cycle.
                    data_low_d = (32'(cnt_q) + 32'd2 >= INHIBIT_CYCLES);
                end
            end
            StBits: begin
                if (fall) begin
                    nfall_d = nfall_inc;
                    if (nfall_q < 4'd8) begin
                        data_low_d = ~byte_q[nfall_q[2:0]];
                    end else if (nfall_q == 4'd8) begin
                        data_low_d = ~parity_q;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = StAck;
                    end
                end
            end
            StAck: begin
                if (fall) begin
                    nfall_d = nfall_inc;
                    state_d = StWaitRel;
                    if (sync_data) begin
                        err_d  = 1'b1;
                        nack_d = 1'b1;
                    end
                end
            end
            StWaitRel: begin
                if (sync_clk && sync_data) begin
                    state_d = StIdle;
                    done_d  = ~nack_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout overrides everything once the device has control of the clock.
        if (state_q == StBits || state_q == StAck || state_q == StWaitRel) begin
            if (cnt_q == TimeoutLast) begin
                state_d    = StIdle;
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                done_d     = 1'b0;
                err_d      = ~nack_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    assign tx_ready          = ready_q;
    assign busy              = busy_q;
    assign kb_clk_drive_low  = clk_low_q;
    assign kb_data_drive_low = data_low_q;
    assign tx_done           = done_q;
    assign tx_error          = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks each frame out of the host and the
// captured frame and pulses are compared with an expected frame built from the command byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned Inhibit = 8;
    localparam int unsigned Timeout = 4000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, kb_clk_drive_low, kb_data_drive_low, busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kb_clk_line, kb_data_line;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    assign kb_clk_line  = ~(kb_clk_drive_low | dev_clk_low);
    assign kb_data_line = ~(kb_data_drive_low | dev_data_low);

    always #500 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(Inhibit),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .kb_clk_in        (kb_clk_line),
        .kb_data_in       (kb_data_line),
        .kb_clk_drive_low (kb_clk_drive_low),
        .kb_data_drive_low(kb_data_drive_low),
        .busy             (busy),
        .tx_done          (tx_done),
        .tx_error         (tx_error)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Device side: waits for request-to-send, clocks 11 bits, samples data on rising edges.
    task automatic device_run(input bit ack_bit, input int stop_after, input int rst_fall,
                              output logic [10:0] frame, output bit got_req);
        frame   = '1;
        got_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kb_data_drive_low && !kb_clk_drive_low) begin
                got_req = 1'b1;
                break;
            end
        end
        if (!got_req) return;
        #5000;
        frame[0] = kb_data_line;
        for (int f = 1; f <= 11; f++) begin
            if (f > stop_after) break;
            dev_clk_low = 1'b1;
            if (f == rst_fall) begin
                #3000;
                rst = 1'b0;
                #1;
                check("rst_outs", {kb_clk_drive_low, kb_data_drive_low, busy, tx_ready,
                                   tx_done, tx_error}, 6'b0);
                dev_clk_low = 1'b0;
                #3000;
                rst = 1'b1;
                return;
            end
            #20000;
            dev_clk_low = 1'b0;
            if (f <= 10) frame[f] = kb_data_line;
            #10000;
            if (f == 10) dev_data_low = ~ack_bit;
            #10000;
        end
        dev_data_low = 1'b0;
    endtask

    // Host side: watches inhibit timing, pokes tx_valid while busy, waits for return to idle.
    task automatic watch(input bit chk_inh, input logic [7:0] orig, output int first_err,
                         output int end_k);
        int clk_low_n  = 0;
        int data_first = -1;
        bit inh_bad    = 1'b0;
        first_err = -1;
        end_k     = -1;
        for (int k = 1; k <= 6000; k++) begin
            if (chk_inh && k <= 12) begin
                if (kb_clk_drive_low) begin
                    clk_low_n++;
                    if (k > Inhibit) inh_bad = 1'b1;
                end
                if (kb_data_drive_low && data_first < 0) data_first = k;
                if (k <= Inhibit && (!busy || tx_ready)) inh_bad = 1'b1;
            end
            if (tx_error && first_err < 0) first_err = k;
            if (k > 12 && tx_ready) begin
                end_k = k;
                break;
            end
            tx_valid = (k inside {[3:5], [60:62]});
            tx_data  = tx_valid ? ~orig : orig;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (chk_inh) begin
            check("inhibit_len", clk_low_n, Inhibit);
            check("start_cycle", data_first, Inhibit);
            check("inhibit_flags", inh_bad, 0);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ack_bit, input int stop_after,
                        input int rst_fall, input bit chk_inh);
        logic [10:0] frame, exp;
        bit          got_req;
        int          first_err, end_k, d0, e0, ones;
        bit          par, aborted, timed_out;
        aborted   = (rst_fall > 0);
        timed_out = (stop_after < 11);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        check("ready_pre", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        fork
            device_run(ack_bit, stop_after, rst_fall, frame, got_req);
            watch(chk_inh, b, first_err, end_k);
        join
        repeat (2) @(negedge clk);

        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0);
        exp = {1'b1, par, b, 1'b0};

        check("got_req", got_req, 1);
        check("ended", end_k > 0, 1);
        if (!aborted && !timed_out) begin
            check("frame", frame, exp);
            check("parity", frame[9], par);
        end
        if (timed_out) begin
            check("partial", frame[5:0], exp[5:0]);
            check("timeout_at", (first_err >= int'(Inhibit + Timeout) - 3) &&
                                (first_err <= int'(Inhibit + Timeout) + 4), 1);
        end
        check("done_n", done_cnt - d0, (!aborted && !timed_out && !ack_bit) ? 1 : 0);
        check("err_n", err_cnt - e0, (!aborted && (timed_out || ack_bit)) ? 1 : 0);
        check("idle_lines", {kb_clk_drive_low, kb_data_drive_low, busy, tx_ready}, 4'b0001);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {kb_clk_drive_low, kb_data_drive_low, busy, tx_ready,
                             tx_done, tx_error}, 6'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {tx_ready, busy}, 2'b10);

        // Bus clock falls while idle must not disturb the next frame.
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            #5000;
            dev_clk_low = 1'b0;
            #5000;
        end
        check("idle_spurious", {tx_ready, kb_clk_drive_low, kb_data_drive_low}, 3'b100);

        send(8'hED, 1'b0, 11, 0, 1'b1);
        send(8'h00, 1'b0, 11, 0, 1'b0);
        send(8'hFF, 1'b0, 11, 0, 1'b0);
        send(8'h01, 1'b0, 11, 0, 1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 11, 0, 1'b0);
        send(8'($urandom), 1'b1, 11, 0, 1'b0);
        send(8'($urandom), 1'b0, 5, 0, 1'b0);
        send(8'($urandom), 1'b0, 11, 4, 1'b0);
        send(8'hF4, 1'b0, 11, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
